ripple_sampler: RTL
===================

RIPPLE_SAMPLER -- requirements
Module: ripple_sampler

Interface
REQ-001 SHALL have parameter DOWN, default 1; 1 means the source count decrements per event, 0 means it increments.
REQ-002 SHALL have parameter STABLE_CYCLES, default 2; this is the number of consecutive equal synchronized samples needed before a value is accepted as stable (legal range 1-15).
REQ-003 SHALL have parameter TOTAL_W, default 16; this is the width of the running event total.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, rising edge active.
REQ-005 SHALL have port rstn, input, 1 bit; synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 SHALL have port cnt_in, input, 4 bits; the asynchronous ripple-counter value, unrelated to clk.
REQ-007 SHALL have port clr, input, 1 bit; synchronous clear of the total and the sticky flags.
REQ-008 SHALL have port out_ready, input, 1 bit; the consumer accepts out_delta.
REQ-009 SHALL have port out_valid, output, 1 bit; out_delta holds an unconsumed event count.
REQ-010 SHALL have port out_delta, output, 5 bits; the events counted since the last handshake.
REQ-011 SHALL have port total, output, TOTAL_W bits; the running event total, wrapping modulo 2^TOTAL_W.
REQ-012 SHALL have port primed, output, 1 bit; a reference stable value has been captured.
REQ-013 SHALL have port ovf, output, 1 bit; sticky flag, set on pending-delta saturation or total wrap.

Function
REQ-014 SHALL pass cnt_in through a two-flop synchronizer (s1, then s2) before any other use.
REQ-015 SHALL count a run of consecutive cycles with an unchanged s2 value; the run restarts at 1 on any change.
REQ-016 SHALL declare s2 stable once the run reaches STABLE_CYCLES.
  - The stable-detect event fires once per run.
REQ-017 SHALL capture the first stable value after reset into last_stable and set primed.
  - No delta is produced for this first capture.
REQ-018 SHALL compute d for each later stable value v where v != last_stable, modulo 16:
  - d = (last_stable - v) when DOWN=1.
  - d = (v - last_stable) when DOWN=0.
  - last_stable is then updated to v.
REQ-019 SHALL produce no event when the stable value v equals last_stable.
REQ-020 SHALL update total <= total + d on the cycle after detection.
  - total wraps modulo 2^TOTAL_W.
  - A carry out of the top bit sets ovf.
REQ-021 SHALL implement a two-state output FSM: IDLE (out_valid=0) and PEND (out_valid=1).
REQ-022 SHALL, in IDLE on event d, load out_delta <= d and go to PEND on the next cycle.
REQ-023 SHALL, in PEND with out_ready=1 and no event, go to IDLE and clear out_delta to 0.
REQ-024 SHALL, in PEND with out_ready=0 and an event d, set out_delta <= min(out_delta + d, 31).
  - Saturation at 31 sets ovf.
  - The FSM stays in PEND.
REQ-025 SHALL, in PEND with out_ready=1 and an event d in the same cycle, set out_delta <= d and stay in PEND.
  - No event is lost or double-counted.
REQ-026 SHALL hold out_delta stable while out_valid=1 and out_ready=0, except for accumulation per REQ-024.
REQ-027 SHALL, on clr=1, zero total and ovf on the next edge.
  - clr does not affect the FSM, out_delta, last_stable or primed.
  - An event coincident with clr loads total <= d.
REQ-028 SHALL give a latency of 2 (synchronizer) + STABLE_CYCLES + 1 clk edges from a settled cnt_in change to out_valid or total updating.

Reset
REQ-029 SHALL, while rstn=0 at a clk edge, set the following on that edge:
  - s1, s2, last_stable and the run counter to 0.
  - primed=0, out_valid=0, out_delta=0, total=0, ovf=0, FSM state IDLE.
REQ-030 SHALL treat reset asserted mid-operation as dominant over clr, events and handshakes.
  - Any pending delta is discarded.
  - After release, the first stable value re-primes per REQ-017.
REQ-031 SHALL ignore out_ready during reset and keep out_valid=0 until a post-prime event.

Verification
REQ-032 SHALL cover: reset, then cnt_in=4'hF held -> primed=1 after 4 edges, out_valid=0, total=0.
REQ-033 SHALL cover: DOWN=1, primed at F, cnt_in stepped to E and held, out_ready=1 -> out_valid pulses for 1 cycle with out_delta=1, total=1.
REQ-034 SHALL cover: DOWN=1, primed at 1, cnt_in to E (wrap through 0) -> out_delta=3, total+=3.
REQ-035 SHALL cover: out_ready=0, with stable steps F->B->7->3->F->B, totalling 4+4+4+4+4=20, then 12 more -> out_delta saturates at 31, ovf=1, total=32.
REQ-036 SHALL cover: a glitch on cnt_in shorter than STABLE_CYCLES after sync -> no event, total unchanged.
REQ-037 SHALL cover: event coincident with out_ready=1 in PEND -> out_valid stays 1 and out_delta shows the new d; the sum of accepted deltas equals total.

Source files
------------

// File: rtl/ripple_sampler.sv
// Samples an asynchronous 4-bit ripple counter, waits for a settled value and
// turns each settled change into an event count with a ready/valid output.
module ripple_sampler #(
  parameter int unsigned DOWN          = 1,
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned TOTAL_W       = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [3:0]         cnt_in,
  input  logic               clr,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [4:0]         out_delta,
  output logic [TOTAL_W-1:0] total,
  output logic               primed,
  output logic               ovf
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  localparam logic [4:0] RUN_MAX    = 5'd16;
  localparam logic [4:0] STABLE_RUN = 5'(STABLE_CYCLES);

  logic [3:0]         s1_q, s1_d, s2_q, s2_d, last_q, last_d;
  logic [4:0]         run_q, run_d;
  logic               primed_q, primed_d, ev_q, ev_d, ovf_q, ovf_d;
  logic [3:0]         evd_q, evd_d;
  logic [0:0]         state_q, state_d;
  logic [4:0]         delta_q, delta_d;
  logic [TOTAL_W-1:0] total_q, total_d;

  logic               stable_c;
  logic [3:0]         diff_c;
  logic [5:0]         acc_c;
  logic [TOTAL_W:0]   sum_c;

  // Next-state logic; the run counter parks above any legal STABLE_CYCLES so
  // the stable-detect fires exactly once per run.
  always_comb begin
    s1_d     = cnt_in;
    s2_d     = s1_q;
    run_d    = run_q;
    last_d   = last_q;
    primed_d = primed_q;
    ev_d     = 1'b0;
    evd_d    = 4'd0;
    state_d  = state_q;
    delta_d  = delta_q;
    total_d  = total_q;
    ovf_d    = ovf_q;

    if (s2_d != s2_q)          run_d = 5'd1;
    else if (run_q != RUN_MAX) run_d = run_q + 5'd1;

    stable_c = (run_q == STABLE_RUN);
    diff_c   = (DOWN != 0) ? (last_q - s2_q) : (s2_q - last_q);

    if (stable_c) begin
      if (!primed_q) begin
        last_d   = s2_q;
        primed_d = 1'b1;
      end else if (s2_q != last_q) begin
        ev_d   = 1'b1;
        evd_d  = diff_c;
        last_d = s2_q;
      end
    end

    acc_c = {1'b0, delta_q} + 6'(evd_q);
    sum_c = {1'b0, total_q} + (TOTAL_W+1)'(evd_q);

    case (state_q)
      IDLE: begin
        if (ev_q) begin
          delta_d = 5'(evd_q);
          state_d = PEND;
        end
      end
      PEND: begin
        if (out_ready) begin
          if (ev_q) begin
            delta_d = 5'(evd_q);
          end else begin
            delta_d = 5'd0;
            state_d = IDLE;
          end
        end else if (ev_q) begin
          if (acc_c > 6'd31) begin
            delta_d = 5'd31;
            ovf_d   = 1'b1;
          end else begin
            delta_d = acc_c[4:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
        delta_d = 5'd0;
      end
    endcase

    if (ev_q) begin
      total_d = sum_c[TOTAL_W-1:0];
      if (sum_c[TOTAL_W]) ovf_d = 1'b1;
    end

    // A clear still keeps an event landing in the same cycle.
    if (clr) begin
      total_d = ev_q ? TOTAL_W'(evd_q) : '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q     <= 4'd0;
      s2_q     <= 4'd0;
      run_q    <= 5'd0;
      last_q   <= 4'd0;
      primed_q <= 1'b0;
      ev_q     <= 1'b0;
      evd_q    <= 4'd0;
      state_q  <= IDLE;
      delta_q  <= 5'd0;
      total_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      run_q    <= run_d;
      last_q   <= last_d;
      primed_q <= primed_d;
      ev_q     <= ev_d;
      evd_q    <= evd_d;
      state_q  <= state_d;
      delta_q  <= delta_d;
      total_q  <= total_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = (state_q == PEND);
  assign out_delta = delta_q;
  assign total     = total_q;
  assign primed    = primed_q;
  assign ovf       = ovf_q;

endmodule
